// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU: default widths, instruction
// field positions and opcode constants used by fetch and decode.
package cpu_pkg;

  // Default datapath widths
  localparam int DEFAULT_ADDR_W  = 8;
  localparam int DEFAULT_INSTR_W = 16;

  // Instruction field positions: opcode [15:11], rd [10:8], imm8 [7:0]
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 11;
  localparam int RD_MSB     = 10;
  localparam int RD_LSB     = 8;
  localparam int IMM_MSB    = 7;
  localparam int IMM_LSB    = 0;

  // Opcode constants
  localparam logic [4:0]  OP_JMPI = 5'b10011;
  localparam logic [4:0]  OP_BRN  = 5'b10111;
  localparam logic [15:0] OP_NOP  = 16'h0000;

  // Fetch unit control states
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_predecode.sv
// Combinational pre-decode of the raw ROM word: flags an unconditional
// JMPI and extracts its immediate target so fetch can fold the jump.
module fetch_predecode
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int INSTR_W = DEFAULT_INSTR_W
) (
  input  logic [INSTR_W-1:0] rom_data,
  output logic               is_jmpi,
  output logic [ADDR_W-1:0]  jmpi_target
);

  // Opcode compare and immediate extraction, zero-extended to the PC width
  always_comb begin
    is_jmpi     = (rom_data[OPCODE_MSB:OPCODE_LSB] == OP_JMPI);
    jmpi_target = ADDR_W'(rom_data[IMM_MSB:IMM_LSB]);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the combinational
// instruction ROM and hands captured words to decode over valid/ready.
// Optional feature macro: FETCH_JMPI_FOLD_EN (JMPI resolved inside fetch).
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int               ADDR_W   = DEFAULT_ADDR_W,
  parameter int               INSTR_W  = DEFAULT_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              load;

`ifdef FETCH_JMPI_FOLD_EN
  logic              is_jmpi;
  logic [ADDR_W-1:0] jmpi_target;

  fetch_predecode #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_predecode (
    .rom_data    (rom_data),
    .is_jmpi     (is_jmpi),
    .jmpi_target (jmpi_target)
  );
`endif

  // The ROM has no latency, so its address is simply the current PC
  assign rom_addr = pc;

  // A new word may be captured when running and the IR slot is free or draining
  assign load = (state == RUN) && fetch_en && (!ir_valid || ir_ready);

  // FSM, PC and IR update; priority is reset > redirect > load > hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      ir       <= INSTR_W'(OP_NOP);
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else begin
      state <= fetch_en ? RUN : IDLE;
      if (redirect_valid) begin
        pc       <= redirect_pc;
        ir_valid <= 1'b0;
      end else if (load) begin
`ifdef FETCH_JMPI_FOLD_EN
        if (is_jmpi) begin
          pc       <= jmpi_target;
          ir_valid <= 1'b0;
        end else begin
          ir       <= rom_data;
          ir_pc    <= pc;
          ir_valid <= 1'b1;
          pc       <= pc + ADDR_W'(1);
        end
`else
        ir       <= rom_data;
        ir_pc    <= pc;
        ir_valid <= 1'b1;
        pc       <= pc + ADDR_W'(1);
`endif
      end else if (ir_valid && ir_ready) begin
        ir_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a combinational ROM model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;

  logic [15:0] rom_mem [256];

  int testCount = 0;
  int failCount = 0;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .ir             (ir),
    .ir_pc          (ir_pc),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Combinational ROM: the word for rom_addr is available in the same cycle
  always_comb rom_data = rom_mem[rom_addr];

  // Advance one rising edge and settle just after it
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Directed sequence following the fetch test plan
  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = 16'hC000 | 16'(i);
    rom_mem[8'h01] = 16'hC801;
    rom_mem[8'hFF] = 16'h9800;

    rst = 1'b1; fetch_en = 1'b0; ir_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 8'h00;
    #2;
    checkOutput("rst_valid", 16'(ir_valid), 16'h0000);
    checkOutput("rst_addr",  16'(rom_addr), 16'h0000);
    checkOutput("rst_ir",    ir,            16'h0000);
    checkOutput("rst_ir_pc", 16'(ir_pc),    16'h0000);
    applyStimulus();
    applyStimulus();
    rst = 1'b0; fetch_en = 1'b1; ir_ready = 1'b1;

    // Edge entering RUN: nothing captured yet
    applyStimulus();
    checkOutput("enter_valid", 16'(ir_valid), 16'h0000);
    checkOutput("enter_addr",  16'(rom_addr), 16'h0000);

    applyStimulus();
    checkOutput("f0_ir",    ir,            16'hC000);
    checkOutput("f0_ir_pc", 16'(ir_pc),    16'h0000);
    checkOutput("f0_valid", 16'(ir_valid), 16'h0001);
    checkOutput("f0_addr",  16'(rom_addr), 16'h0001);

    applyStimulus();
    checkOutput("f1_ir",    ir,            16'hC801);
    checkOutput("f1_ir_pc", 16'(ir_pc),    16'h0001);
    checkOutput("f1_addr",  16'(rom_addr), 16'h0002);

    // Backpressure for three cycles: everything holds
    ir_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus();
      checkOutput("bp_ir",    ir,            16'hC801);
      checkOutput("bp_ir_pc", 16'(ir_pc),    16'h0001);
      checkOutput("bp_addr",  16'(rom_addr), 16'h0002);
      checkOutput("bp_valid", 16'(ir_valid), 16'h0001);
    end
    ir_ready = 1'b1;
    applyStimulus();
    checkOutput("rel_ir",    ir,         16'hC002);
    checkOutput("rel_ir_pc", 16'(ir_pc), 16'h0002);
    checkOutput("rel_addr",  16'(rom_addr), 16'h0003);

    // Redirect squashes even with ir_ready low
    redirect_valid = 1'b1; redirect_pc = 8'h0C; ir_ready = 1'b0;
    applyStimulus();
    checkOutput("redir_valid", 16'(ir_valid), 16'h0000);
    checkOutput("redir_addr",  16'(rom_addr), 16'h000C);
    redirect_valid = 1'b0; ir_ready = 1'b1;
    applyStimulus();
    checkOutput("redir_ir_pc", 16'(ir_pc),    16'h000C);
    checkOutput("redir_ir",    ir,            16'hC00C);
    checkOutput("redir_vld2",  16'(ir_valid), 16'h0001);

    // PC wrap through address FF holding 16'h9800 (a JMPI to 00)
    redirect_valid = 1'b1; redirect_pc = 8'hFE;
    applyStimulus();
    redirect_valid = 1'b0;
    applyStimulus();
    checkOutput("fe_ir_pc", 16'(ir_pc),    16'h00FE);
    checkOutput("fe_addr",  16'(rom_addr), 16'h00FF);
    applyStimulus();
`ifdef FETCH_JMPI_FOLD_EN
    checkOutput("fold_valid", 16'(ir_valid), 16'h0000);
    checkOutput("fold_addr",  16'(rom_addr), 16'h0000);
`else
    checkOutput("wrap_ir",    ir,            16'h9800);
    checkOutput("wrap_ir_pc", 16'(ir_pc),    16'h00FF);
    checkOutput("wrap_addr",  16'(rom_addr), 16'h0000);
`endif
    applyStimulus();
    checkOutput("post_wrap_ir_pc", 16'(ir_pc), 16'h0000);
    checkOutput("post_wrap_ir",    ir,         16'hC000);
    checkOutput("post_wrap_addr",  16'(rom_addr), 16'h0001);

    // Drop fetch_en: the accepted word drains and the PC parks
    fetch_en = 1'b0;
    applyStimulus();
    checkOutput("idle_valid", 16'(ir_valid), 16'h0000);
    checkOutput("idle_addr",  16'(rom_addr), 16'h0001);
    applyStimulus();
    checkOutput("idle_addr2", 16'(rom_addr), 16'h0001);

    // Asynchronous reset between edges takes effect immediately
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_addr",  16'(rom_addr), 16'h0000);
    checkOutput("arst_ir",    ir,            16'h0000);
    checkOutput("arst_valid", 16'(ir_valid), 16'h0000);
    applyStimulus();
    rst = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("park_valid", 16'(ir_valid), 16'h0000);
    checkOutput("park_addr",  16'(rom_addr), 16'h0000);

    // Re-enable: one edge to enter RUN, then the first word appears
    fetch_en = 1'b1;
    applyStimulus();
    checkOutput("reen_valid", 16'(ir_valid), 16'h0000);
    applyStimulus();
    checkOutput("reen_ir",    ir,            16'hC000);
    checkOutput("reen_vld2",  16'(ir_valid), 16'h0001);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
